// File: rtl/mem_responder.sv
// Memory-side responder: critical-word-first 4-beat line refills and full-line write-backs.
// Optional macro MEM_BEAT_GAP_EN inserts one idle cycle between refill beats.
module mem_responder #(
    parameter int WORD_WIDTH     = 32,
    parameter int ADR_WIDTH      = 32,
    parameter int LINE_WIDTH     = 128,
    parameter int LINE_ADR_WIDTH = 10,
    parameter int LATENCY        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_cc2mem,
    input  logic [ADR_WIDTH-1:0]  adr_cc2mem,
    output logic                  ack_mem2cc,
    output logic [WORD_WIDTH-1:0] dat_mem2cc,
    input  logic                  wb_req_mshr2mem,
    input  logic [ADR_WIDTH-1:0]  wb_adr_mshr2mem,
    input  logic [LINE_WIDTH-1:0] wb_dat_mshr2mem,
    output logic                  wb_ack_mem2mshr,
    output logic                  busy_mem
);

    typedef enum logic [1:0] {IDLE, WB, WAIT, BURST} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);
`ifdef MEM_BEAT_GAP_EN
    localparam logic GAP_EN = 1'b1;
`else
    localparam logic GAP_EN = 1'b0;
`endif

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic [1:0]                beat_q, beat_d;
    logic                      gap_q, gap_d;
    logic                      pend_q, pend_d;
    logic [LINE_ADR_WIDTH-1:0] rd_idx_q, rd_idx_d;
    logic [1:0]                rd_off_q, rd_off_d;
    logic [LINE_ADR_WIDTH-1:0] wb_idx_q, wb_idx_d;
    logic [LINE_WIDTH-1:0]     wb_dat_q, wb_dat_d;
    logic                      wb_ack_q, wb_ack_d;

    logic [LINE_WIDTH-1:0]     store [2**LINE_ADR_WIDTH];
    logic [LINE_WIDTH-1:0]     rd_line;
    logic [WORD_WIDTH-1:0]     line_words [4];
    logic [1:0]                word_sel;

    // Only the line index and word offset matter; the rest of each address is don't-care.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr_cc2mem[ADR_WIDTH-1:LINE_ADR_WIDTH+4], adr_cc2mem[1:0],
                               wb_adr_mshr2mem[ADR_WIDTH-1:LINE_ADR_WIDTH+4], wb_adr_mshr2mem[3:0]};

    always_comb begin
        // NOTE: every variable gets its default first so no path leaves one unassigned (no latch).
        state_d  = state_q;
        cnt_d    = cnt_q;
        beat_d   = beat_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        rd_idx_d = rd_idx_q;
        rd_off_d = rd_off_q;
        wb_idx_d = wb_idx_q;
        wb_dat_d = wb_dat_q;
        wb_ack_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_cc2mem) begin
                    rd_idx_d = adr_cc2mem[LINE_ADR_WIDTH+3:4];
                    rd_off_d = adr_cc2mem[3:2];
                end
                if (wb_req_mshr2mem) begin
                    // A simultaneous read is parked and serviced right after the write-back.
                    wb_idx_d = wb_adr_mshr2mem[LINE_ADR_WIDTH+3:4];
                    wb_dat_d = wb_dat_mshr2mem;
                    pend_d   = req_cc2mem;
                    state_d  = WB;
                end else if (req_cc2mem) begin
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end
            end
            WB: begin
                wb_ack_d = 1'b1;
                if (pend_q) begin
                    pend_d  = 1'b0;
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    beat_d  = 2'd0;
                    gap_d   = 1'b0;
                    state_d = BURST;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (beat_q == 2'd3) begin
                    beat_d  = 2'd0;
                    state_d = IDLE;
                end else begin
                    beat_d = beat_q + 2'd1;
                    gap_d  = GAP_EN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            beat_q   <= '0;
            gap_q    <= 1'b0;
            pend_q   <= 1'b0;
            rd_idx_q <= '0;
            rd_off_q <= '0;
            wb_idx_q <= '0;
            wb_dat_q <= '0;
            wb_ack_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            rd_idx_q <= rd_idx_d;
            rd_off_q <= rd_off_d;
            wb_idx_q <= wb_idx_d;
            wb_dat_q <= wb_dat_d;
            wb_ack_q <= wb_ack_d;
        end
    end

    // NOTE: the backing store has no reset so its contents survive rst like real memory.
    always_ff @(posedge clk) begin
        if (state_q == WB) store[wb_idx_q] <= wb_dat_q;
    end

    assign rd_line = store[rd_idx_q];
    for (genvar k = 0; k < 4; k++) begin : g_words
        assign line_words[k] = rd_line[k*WORD_WIDTH +: WORD_WIDTH];
    end
    assign word_sel = rd_off_q + beat_q;

    assign ack_mem2cc      = (state_q == BURST) && !gap_q;
    assign dat_mem2cc      = ack_mem2cc ? line_words[word_sel] : '0;
    assign wb_ack_mem2mshr = wb_ack_q;
    assign busy_mem        = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: scoreboard of expected beats, immediate-assertion checks.
// Honours MEM_BEAT_GAP_EN for the expected beat spacing.
module tb_mem_responder;

    localparam int LAT = 4;
`ifdef MEM_BEAT_GAP_EN
    localparam int STRIDE = 2;
`else
    localparam int STRIDE = 1;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req_cc2mem = 1'b0;
    logic [31:0]  adr_cc2mem = '0;
    logic         ack_mem2cc;
    logic [31:0]  dat_mem2cc;
    logic         wb_req_mshr2mem = 1'b0;
    logic [31:0]  wb_adr_mshr2mem = '0;
    logic [127:0] wb_dat_mshr2mem = '0;
    logic         wb_ack_mem2mshr;
    logic         busy_mem;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [31:0]  sb [$];

    logic [127:0] line40;
    logic [127:0] line80;

    mem_responder #(.LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_cc2mem      (req_cc2mem),
        .adr_cc2mem      (adr_cc2mem),
        .ack_mem2cc      (ack_mem2cc),
        .dat_mem2cc      (dat_mem2cc),
        .wb_req_mshr2mem (wb_req_mshr2mem),
        .wb_adr_mshr2mem (wb_adr_mshr2mem),
        .wb_dat_mshr2mem (wb_dat_mshr2mem),
        .wb_ack_mem2mshr (wb_ack_mem2mshr),
        .busy_mem        (busy_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected refill order: critical word first, wrapping mod 4.
    task automatic push_line(input logic [31:0] adr, input logic [127:0] line);
        int c;
        c = int'(adr[3:2]);
        for (int b = 0; b < 4; b++) sb.push_back(line[32*((c + b) % 4) +: 32]);
    endtask

    // Steps to each beat slot; optionally injects a request or asserts reset after a given beat.
    task automatic collect_burst(input int inject_after, input int reset_after);
        int beats;
        logic [31:0] exp;
        beats = 0;
        for (int i = 0; i < 3*STRIDE + 1; i++) begin
            @(negedge clk);
            req_cc2mem = 1'b0;
            if (i % STRIDE == 0) begin
                exp = (sb.size() != 0) ? sb.pop_front() : 32'hDEAD_BEEF;
                check("beat_ack", 32'(ack_mem2cc), 32'd1);
                check("beat_dat", dat_mem2cc, exp);
                beats++;
                if (beats == inject_after) begin
                    req_cc2mem = 1'b1;
                    adr_cc2mem = 32'h40;
                end
                if (beats == reset_after) begin
                    rst = 1'b0;
                    #1;
                    check("rst_ack", 32'(ack_mem2cc), 32'd0);
                    check("rst_dat", dat_mem2cc, 32'd0);
                    check("rst_busy", 32'(busy_mem), 32'd0);
                    sb.delete();
                    return;
                end
            end else begin
                check("gap_ack", 32'(ack_mem2cc), 32'd0);
                check("gap_dat", dat_mem2cc, 32'd0);
            end
        end
        @(negedge clk);
        req_cc2mem = 1'b0;
        check("post_ack", 32'(ack_mem2cc), 32'd0);
        check("post_busy", 32'(busy_mem), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] adr, input logic [127:0] line,
                           input int inject_after, input int reset_after);
        push_line(adr, line);
        req_cc2mem = 1'b1;
        adr_cc2mem = adr;
        @(negedge clk);
        req_cc2mem = 1'b0;
        check("lat_busy", 32'(busy_mem), 32'd1);
        check("lat_ack", 32'(ack_mem2cc), 32'd0);
        repeat (LAT - 1) begin
            @(negedge clk);
            check("lat_ack", 32'(ack_mem2cc), 32'd0);
        end
        collect_burst(inject_after, reset_after);
    endtask

    task automatic do_wb(input logic [31:0] adr, input logic [127:0] line);
        wb_req_mshr2mem = 1'b1;
        wb_adr_mshr2mem = adr;
        wb_dat_mshr2mem = line;
        @(negedge clk);
        wb_req_mshr2mem = 1'b0;
        check("wb_ack_early", 32'(wb_ack_mem2mshr), 32'd0);
        check("wb_busy", 32'(busy_mem), 32'd1);
        @(negedge clk);
        check("wb_ack", 32'(wb_ack_mem2mshr), 32'd1);
        @(negedge clk);
        check("wb_ack_pulse", 32'(wb_ack_mem2mshr), 32'd0);
        check("wb_idle", 32'(busy_mem), 32'd0);
    endtask

    task automatic quiet(input int cycles, input string tag);
        repeat (cycles) begin
            @(negedge clk);
            check(tag, 32'(ack_mem2cc), 32'd0);
            check(tag, 32'(busy_mem), 32'd0);
        end
    endtask

    initial begin
        line40 = {32'h44, 32'h33, 32'h22, 32'h11};
        line80 = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

        // Reset state
        @(negedge clk);
        check("reset_ack", 32'(ack_mem2cc), 32'd0);
        check("reset_dat", dat_mem2cc, 32'd0);
        check("reset_wb_ack", 32'(wb_ack_mem2mshr), 32'd0);
        check("reset_busy", 32'(busy_mem), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Write-back then read of the critical word at offset 2
        do_wb(32'h40, line40);
        do_read(32'h48, line40, 0, 0);

        // All four critical-word offsets, issued back to back
        do_read(32'h40, line40, 0, 0);
        do_read(32'h44, line40, 0, 0);
        do_read(32'h48, line40, 0, 0);
        do_read(32'h4C, line40, 0, 0);

        // Simultaneous read and write-back: write-back first, then the read sees new data
        push_line(32'h84, line80);
        req_cc2mem      = 1'b1;
        adr_cc2mem      = 32'h84;
        wb_req_mshr2mem = 1'b1;
        wb_adr_mshr2mem = 32'h80;
        wb_dat_mshr2mem = line80;
        @(negedge clk);
        req_cc2mem      = 1'b0;
        wb_req_mshr2mem = 1'b0;
        check("sim_wb_ack_early", 32'(wb_ack_mem2mshr), 32'd0);
        check("sim_busy", 32'(busy_mem), 32'd1);
        @(negedge clk);
        check("sim_wb_ack", 32'(wb_ack_mem2mshr), 32'd1);
        check("sim_ack", 32'(ack_mem2cc), 32'd0);
        repeat (LAT - 1) begin
            @(negedge clk);
            check("sim_lat_ack", 32'(ack_mem2cc), 32'd0);
        end
        collect_burst(0, 0);

        // Request during BURST is ignored
        do_read(32'h40, line40, 1, 0);
        quiet(LAT + 3, "ignored_req");

        // Reset mid-burst aborts at once; the store survives
        do_read(32'h40, line40, 0, 2);
        @(negedge clk);
        rst = 1'b1;
        quiet(LAT + 6, "after_reset");
        do_read(32'h40, line40, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
